// File: rtl/mem_adapter_pkg.sv
// Shared types and helpers for the multi-port cacheline/burst adapter.
// Port and issue state encodings, beat index sizing and line-address masking.
package mem_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD_PEND
    } port_state_e;

    typedef enum logic {
        I_IDLE,
        I_WRITE
    } issue_state_e;

    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic logic [31:0] line_addr(
        input logic [31:0] a,
        input int          line_bits
    );
        logic [31:0] m;
        m = 32'(line_bits / 8) - 32'd1;
        return a & ~m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves past the grantee only when the caller consumes the grant.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [IW-1:0] ptr;
    int            j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!grant_vld && req[j]) begin
                grant_vld = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance && grant_vld) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/multi_port_line_adapter.sv
// N-port cacheline to burst adapter: round-robin issue, one outstanding
// read per port matched by returned line address, same-line read merging.
module multi_port_line_adapter
    import mem_adapter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*32-1:0]        dfp_addr,
    input  logic [NUM_PORTS-1:0]           dfp_read,
    input  logic [NUM_PORTS-1:0]           dfp_write,
    input  logic [NUM_PORTS*LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0]           dfp_rdata,
    output logic [NUM_PORTS-1:0]           dfp_resp,
    output logic [31:0]                    bmem_addr,
    output logic                           bmem_read,
    output logic                           bmem_write,
    output logic [BEAT_BITS-1:0]           bmem_wdata,
    input  logic                           bmem_ready,
    input  logic [31:0]                    bmem_raddr,
    input  logic [BEAT_BITS-1:0]           bmem_rdata,
    input  logic                           bmem_rvalid,
    output logic                           err_unmatched
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int BW    = beat_idx_w(BEATS);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
        $error("LINE_BITS/BEAT_BITS must be a power of 2 >= 2");
    end

    port_state_e          st_q   [NUM_PORTS];
    logic                 wr_q   [NUM_PORTS];
    logic [31:0]          addr_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] match;
    logic [NUM_PORTS-1:0] wr_resp_q;
    logic [NUM_PORTS-1:0] rd_resp_q;
    logic [NUM_PORTS-1:0] grant;
    logic [PW-1:0]        gidx;
    logic                 gvld;
    logic                 advance;

    issue_state_e         is_q, is_d;
    logic [PW-1:0]        wport_q, wport_d;
    logic [BW-1:0]        wcnt_q, wcnt_d;
    logic                 rd_take;
    logic                 wr_last;
    logic                 merge_ok;
    logic [PW-1:0]        wsel;
    logic [BW-1:0]        bsel;
    logic [BEAT_BITS-1:0] wbeat;

    logic [BW-1:0]        rcnt_q;
    logic [BEAT_BITS-1:0] rbuf_q [BEATS-1];
    logic [LINE_BITS-1:0] rline;
    logic [LINE_BITS-1:0] rdata_q;
    logic                 ret_last;
    logic                 err_q;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_vec),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_vld (gvld)
    );

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign req_vec[i] = (st_q[i] == REQ);
        assign match[i]   = (st_q[i] == RD_PEND) && !rd_resp_q[i] &&
                            (addr_q[i] == line_addr(bmem_raddr, LINE_BITS));

        // Sampling is held off during the response pulse so a request
        // still high then is treated as a fresh one on the next cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q[i]   <= IDLE;
                wr_q[i]   <= 1'b0;
                addr_q[i] <= '0;
            end else begin
                unique case (st_q[i])
                    IDLE: begin
                        if ((dfp_read[i] || dfp_write[i]) && !dfp_resp[i]) begin
                            st_q[i]   <= REQ;
                            wr_q[i]   <= dfp_write[i];
                            addr_q[i] <= line_addr(dfp_addr[i*32 +: 32], LINE_BITS);
                        end
                    end
                    REQ: begin
                        if (rd_take && grant[i]) begin
                            st_q[i] <= RD_PEND;
                        end else if (wr_last && wport_q == PW'(i)) begin
                            st_q[i] <= IDLE;
                        end
                    end
                    RD_PEND: begin
                        if (rd_resp_q[i]) st_q[i] <= IDLE;
                    end
                    default: st_q[i] <= IDLE;
                endcase
            end
        end
    end

    assign ret_last = bmem_rvalid && (rcnt_q == BW'(BEATS - 1));

    // A pending read whose burst completes now cannot absorb a new requester.
    always_comb begin
        merge_ok = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (st_q[j] == RD_PEND && !rd_resp_q[j] && addr_q[j] == addr_q[gidx])
                merge_ok = 1'b1;
        end
        if (ret_last) merge_ok = 1'b0;
    end

    always_comb begin
        wsel  = (is_q == I_WRITE) ? wport_q : gidx;
        bsel  = (is_q == I_WRITE) ? wcnt_q : '0;
        wbeat = dfp_wdata[int'(wsel)*LINE_BITS + int'(bsel)*BEAT_BITS +: BEAT_BITS];
    end

    always_comb begin
        is_d       = is_q;
        wport_d    = wport_q;
        wcnt_d     = wcnt_q;
        advance    = 1'b0;
        rd_take    = 1'b0;
        wr_last    = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        unique case (is_q)
            I_IDLE: begin
                if (gvld) begin
                    if (wr_q[gidx]) begin
                        advance    = 1'b1;
                        is_d       = I_WRITE;
                        wport_d    = gidx;
                        bmem_write = 1'b1;
                        bmem_addr  = addr_q[gidx];
                        bmem_wdata = wbeat;
                        wcnt_d     = bmem_ready ? BW'(1) : '0;
                    end else if (merge_ok) begin
                        advance = 1'b1;
                        rd_take = 1'b1;
                    end else begin
                        bmem_read = 1'b1;
                        bmem_addr = addr_q[gidx];
                        advance   = bmem_ready;
                        rd_take   = bmem_ready;
                    end
                end
            end
            I_WRITE: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q[wport_q];
                bmem_wdata = wbeat;
                if (bmem_ready) begin
                    wcnt_d = wcnt_q + BW'(1);
                    if (wcnt_q == BW'(BEATS - 1)) begin
                        wr_last = 1'b1;
                        is_d    = I_IDLE;
                    end
                end
            end
            default: is_d = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_q      <= I_IDLE;
            wport_q   <= '0;
            wcnt_q    <= '0;
            wr_resp_q <= '0;
        end else begin
            is_q      <= is_d;
            wport_q   <= wport_d;
            wcnt_q    <= wcnt_d;
            wr_resp_q <= '0;
            if (wr_last) wr_resp_q[wport_q] <= 1'b1;
        end
    end

    always_comb begin
        rline = '0;
        for (int b = 0; b < BEATS - 1; b++) begin
            rline[b*BEAT_BITS +: BEAT_BITS] = rbuf_q[b];
        end
        rline[(BEATS-1)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rd_resp_q <= '0;
            err_q     <= 1'b0;
            for (int b = 0; b < BEATS - 1; b++) rbuf_q[b] <= '0;
        end else begin
            rd_resp_q <= '0;
            if (bmem_rvalid) begin
                rcnt_q <= rcnt_q + BW'(1);
                if (ret_last) begin
                    rdata_q   <= rline;
                    rd_resp_q <= match;
                    if (match == '0) err_q <= 1'b1;
                end else begin
                    rbuf_q[rcnt_q] <= bmem_rdata;
                end
            end
        end
    end

    assign dfp_rdata     = rdata_q;
    assign dfp_resp      = wr_resp_q | rd_resp_q;
    assign err_unmatched = err_q;

    a_burst_contig: assert property (
        @(posedge clk) disable iff (!rst) (rcnt_q != '0) |-> bmem_rvalid
    ) else $error("bmem_rvalid gap inside a return burst");

endmodule

// File: tb/tb_multi_port_line_adapter.sv
// Directed bench for multi_port_line_adapter (2 ports, 256-bit line, 64-bit beat).
module tb_multi_port_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  dfp_addr;
    logic [1:0]   dfp_read;
    logic [1:0]   dfp_write;
    logic [511:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic [1:0]   dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         err_unmatched;

    int checks = 0;
    int errors = 0;
    int n_rd   = 0;
    int rd0;

    multi_port_line_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .dfp_addr      (dfp_addr),
        .dfp_read      (dfp_read),
        .dfp_write     (dfp_write),
        .dfp_wdata     (dfp_wdata),
        .dfp_rdata     (dfp_rdata),
        .dfp_resp      (dfp_resp),
        .bmem_addr     (bmem_addr),
        .bmem_read     (bmem_read),
        .bmem_write    (bmem_write),
        .bmem_wdata    (bmem_wdata),
        .bmem_ready    (bmem_ready),
        .bmem_raddr    (bmem_raddr),
        .bmem_rdata    (bmem_rdata),
        .bmem_rvalid   (bmem_rvalid),
        .err_unmatched (err_unmatched)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && bmem_read && bmem_ready) n_rd++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    task automatic burst(input logic [31:0] a, input logic [63:0] base);
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = base + 64'(b);
            step();
        end
        bmem_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rdy_tab[6];
        int beat_tab[6];
        rdy_tab  = '{1, 0, 1, 1, 0, 1};
        beat_tab = '{0, 1, 1, 2, 3, 3};

        rst         = 1'b0;
        dfp_addr    = '0;
        dfp_read    = '0;
        dfp_write   = '0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        step();
        step();
        chk("rst_read", bmem_read, 1'b0);
        chk("rst_write", bmem_write, 1'b0);
        chk("rst_resp", dfp_resp, 2'b00);
        chk("rst_err", err_unmatched, 1'b0);
        chk("rst_rdata", dfp_rdata, 256'h0);
        rst = 1'b1;
        step();

        // single read, port 0
        dfp_read         = 2'b01;
        dfp_addr[31:0]   = 32'h1000;
        bmem_ready       = 1'b1;
        step();
        chk("s1_read", bmem_read, 1'b1);
        chk("s1_addr", bmem_addr, 32'h1000);
        step();
        chk("s1_read_once", bmem_read, 1'b0);
        chk("s1_no_early_resp", dfp_resp, 2'b00);
        burst(32'h1000, 64'h0);
        chk("s1_resp", dfp_resp, 2'b01);
        chk("s1_line", dfp_rdata, {64'h3, 64'h2, 64'h1, 64'h0});
        dfp_read = 2'b00;
        step();
        chk("s1_resp_end", dfp_resp, 2'b00);

        // single write, port 1, ready toggling
        dfp_write        = 2'b10;
        dfp_addr[63:32]  = 32'h2000;
        dfp_wdata[511:256] = mk_line(64'hB0);
        step();
        for (int n = 0; n < 6; n++) begin
            bmem_ready = rdy_tab[n][0];
            chk($sformatf("s2_write_c%0d", n), bmem_write, 1'b1);
            chk($sformatf("s2_addr_c%0d", n), bmem_addr, 32'h2000);
            chk($sformatf("s2_beat_c%0d", n), bmem_wdata, 64'hB0 + 64'(beat_tab[n]));
            chk($sformatf("s2_noresp_c%0d", n), dfp_resp, 2'b00);
            step();
        end
        bmem_ready = 1'b1;
        chk("s2_resp", dfp_resp, 2'b10);
        chk("s2_write_done", bmem_write, 1'b0);
        dfp_write = 2'b00;
        step();
        chk("s2_resp_end", dfp_resp, 2'b00);

        // two reads same cycle, out-of-order return
        dfp_read  = 2'b11;
        dfp_addr  = {32'h4000, 32'h3000};
        step();
        chk("s3_first_read", bmem_read, 1'b1);
        chk("s3_first_addr", bmem_addr, 32'h3000);
        step();
        chk("s3_second_read", bmem_read, 1'b1);
        chk("s3_second_addr", bmem_addr, 32'h4000);
        step();
        chk("s3_idle", bmem_read, 1'b0);
        burst(32'h4000, 64'h40);
        chk("s3_resp1", dfp_resp, 2'b10);
        chk("s3_line1", dfp_rdata, mk_line(64'h40));
        dfp_read = 2'b01;
        step();
        chk("s3_gap", dfp_resp, 2'b00);
        burst(32'h3000, 64'h30);
        chk("s3_resp0", dfp_resp, 2'b01);
        chk("s3_line0", dfp_rdata, mk_line(64'h30));
        dfp_read = 2'b00;
        step();

        // same-line merge
        rd0       = n_rd;
        dfp_read  = 2'b11;
        dfp_addr  = {32'h5000, 32'h5000};
        step();
        chk("s4_read", bmem_read, 1'b1);
        chk("s4_addr", bmem_addr, 32'h5000);
        step();
        chk("s4_merged_no_read", bmem_read, 1'b0);
        step();
        burst(32'h5000, 64'h50);
        chk("s4_resp_both", dfp_resp, 2'b11);
        chk("s4_line", dfp_rdata, mk_line(64'h50));
        chk("s4_one_burst", 32'(n_rd - rd0), 32'd1);
        dfp_read = 2'b00;
        step();
        chk("s4_resp_end", dfp_resp, 2'b00);

        // write burst on port 0 while port 1 read data returns
        dfp_read        = 2'b10;
        dfp_addr[63:32] = 32'h7000;
        step();
        chk("s5_read", bmem_read, 1'b1);
        chk("s5_raddr", bmem_addr, 32'h7000);
        step();
        dfp_write          = 2'b01;
        dfp_addr[31:0]     = 32'h8000;
        dfp_wdata[255:0]   = mk_line(64'hC0);
        step();
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h7000;
            bmem_rdata  = 64'h70 + 64'(b);
            chk($sformatf("s5_write_b%0d", b), bmem_write, 1'b1);
            chk($sformatf("s5_waddr_b%0d", b), bmem_addr, 32'h8000);
            chk($sformatf("s5_wbeat_b%0d", b), bmem_wdata, 64'hC0 + 64'(b));
            step();
        end
        bmem_rvalid = 1'b0;
        chk("s5_resp_both", dfp_resp, 2'b11);
        chk("s5_line", dfp_rdata, mk_line(64'h70));
        chk("s5_write_done", bmem_write, 1'b0);
        dfp_read  = 2'b00;
        dfp_write = 2'b00;
        step();
        chk("s5_resp_end", dfp_resp, 2'b00);
        chk("s5_err_clear", err_unmatched, 1'b0);

        // reset mid-write, then stray return burst
        dfp_write        = 2'b01;
        dfp_addr[31:0]   = 32'h9000;
        dfp_wdata[255:0] = mk_line(64'hD0);
        step();
        step();
        step();
        chk("s6_beat2", bmem_wdata, 64'hD2);
        rst = 1'b0;
        #1;
        chk("s6_rst_write", bmem_write, 1'b0);
        chk("s6_rst_read", bmem_read, 1'b0);
        chk("s6_rst_addr", bmem_addr, 32'h0);
        chk("s6_rst_wdata", bmem_wdata, 64'h0);
        chk("s6_rst_resp", dfp_resp, 2'b00);
        chk("s6_rst_rdata", dfp_rdata, 256'h0);
        dfp_write = 2'b00;
        step();
        step();
        chk("s6_rst_hold_resp", dfp_resp, 2'b00);
        rst = 1'b1;
        step();
        chk("s6_err_before", err_unmatched, 1'b0);
        burst(32'h6000, 64'h60);
        chk("s6_stray_resp", dfp_resp, 2'b00);
        chk("s6_err_set", err_unmatched, 1'b1);
        step();
        chk("s6_err_sticky", err_unmatched, 1'b1);
        chk("s6_no_resp", dfp_resp, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
